histogram_median_sequencer: RTL and testbench
=============================================

// Module: histogram_median_sequencer
// PURPOSE
//  Frame-level controller for the computeHistogram datapath. Per frame it sequences
//  ACCUM -> READ -> CLEAR on the datapath's start/read/clear strobes, and counts events.
//  While the histograms stream out, it finds the median x and y bin indices.
//  Sits between the event/pixel front end and the downstream centroid/tracking logic.
// PARAMETERS
//  IMWIDTH        240      x-histogram bins; must match the datapath
//  IMHEIGHT       180      y-histogram bins; must match the datapath
//  TIMEOUT_CYCLES 2**20    ACCUM watchdog limit (used only with FRAME_TIMEOUT_EN)
// PORTS
//  clk             in   1   single clock, all logic on posedge
//  reset           in   1   synchronous, active-high
//  frameStart      in   1   1-cycle pulse: open accumulation window
//  frameEnd        in   1   1-cycle pulse: close accumulation window
//  pixelValid      in   1   event present on pixelData this cycle
//  pixelData       in   1   event bit (1 = count)
//  startHistogram  out  1   to datapath: = pixelValid while in ACCUM, else 0
//  readHistogram   out  1   to datapath: high throughout READ
//  clearHistogram  out  1   to datapath: high throughout CLEAR
//  xHistogramIn    in   8   datapath xHistogramOut
//  yHistogramIn    in   8   datapath yHistogramOut
//  xValid, yValid  in   1   datapath bin-valid strobes
//  histogramClear  in   1   datapath: all bins zeroed
//  busy            out  1   state != IDLE
//  medianX         out  8   median x bin index, held until next result
//  medianY         out  8   median y bin index, held until next result
//  medianValid     out  1   1-cycle pulse: medianX/Y/frameEmpty updated
//  frameEmpty      out  1   last frame had zero events
//  frameDropped    out  1   1-cycle pulse: frameStart ignored (not IDLE)
// BEHAVIOUR
//  States: IDLE, ACCUM, GAP1, READ, GAP2, CLEAR, DONE.
//  Reset: state=CLEAR, so the datapath is always scrubbed after reset, including
//   reset mid-frame. All outputs 0 except clearHistogram=1 and busy=1.
//  IDLE: frameStart -> ACCUM, eventCount (16b) <= 0.
//  ACCUM: eventCount += pixelValid&pixelData, saturating at 16'hFFFF.
//   On frameEnd -> GAP1. frameEnd together with frameStart: frameEnd wins.
//  GAP1/GAP2: 1 cycle with all strobes 0, so datapath counters return to 0.
//   GAP1 -> READ. GAP2 -> CLEAR.
//  READ: target = (eventCount+1)>>1; per-axis 16b cumulative sums start at 0.
//   On each cycle with xValid=1, the sample is bin k (k = count of prior valid x samples).
//   cum += xHistogramIn. The first k where cum >= target latches medianX=k.
//   y is identical with yValid/yHistogramIn/medianY.
//   Leave READ after IMWIDTH+1 cycles (x and y streams both complete) -> GAP2.
//   No bin reaches target (datapath drops final bin) -> median = last valid index.
//  CLEAR: hold clearHistogram until histogramClear=1, then -> DONE.
//  DONE: medianValid=1 for 1 cycle. frameEmpty=(eventCount==0); empty frame gives medianX=medianY=0.
//   Post-reset pass (CLEAR from reset) skips the pulse and goes CLEAR -> IDLE.
//  frameStart in any state but IDLE: ignored, frameDropped pulses next cycle.
//  Latency: frameEnd to medianValid = 1 + 1 + (IMWIDTH+1) + 1 + clear time + 1 cycles.
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined: 32b watchdog counts in ACCUM. At TIMEOUT_CYCLES without
//   frameEnd, force -> GAP1 and set sticky output timedOut (cleared by next frameStart).
//  FRAME_TIMEOUT_EN undefined: no watchdog and no timedOut port; ACCUM waits forever.
// STRUCTURE
//  Package histogram_ctrl_pkg: state enum, IMWIDTH/IMHEIGHT defaults,
//   COUNT_W=16, BIN_W=8 and IDX_W=8 constants.
//  Sub-module median_search (instantiated twice, x and y): inputs clear, target, valid, binIn;
//   it keeps the index/cum counters and outputs a found flag and medianIdx.
//  The top level holds the FSM, eventCount, gap/read timers and the optional watchdog.
// TESTING
//  Bench pairs the DUT with the real computeHistogram plus a scoreboard model.
//  1: 5 events at x=10,10,20,30,40 -> target 3, medianX=20, frameEmpty=0, one medianValid.
//  2: frame with 0 events -> medianX=medianY=0, frameEmpty=1, histogramClear reached.
//  3: frameStart during READ -> frameDropped pulse, FSM unaffected, result still correct.
//  4: reset asserted mid-ACCUM after 50 events -> CLEAR, no medianValid.
//     Next frame of 1 event at (3,7) -> medianX=3, medianY=7.
//  5: frameStart+frameEnd same cycle in ACCUM -> GAP1 taken; back-to-back frames give fresh results.
//  6: FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=100, no frameEnd -> GAP1 at cycle 100, timedOut=1.

Source files
------------

// File: rtl/histogram_ctrl_pkg.sv
// Shared types and constants for the histogram median sequencer.
package histogram_ctrl_pkg;

  localparam int unsigned IMWIDTH_DEF  = 240;
  localparam int unsigned IMHEIGHT_DEF = 180;
  localparam int unsigned COUNT_W      = 16;
  localparam int unsigned BIN_W        = 8;
  localparam int unsigned IDX_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_GAP1,
    S_READ,
    S_GAP2,
    S_CLEAR,
    S_DONE
  } state_t;

  // Rank of the median event: ceil(count/2), computed without 16-bit overflow.
  function automatic logic [COUNT_W-1:0] median_target(input logic [COUNT_W-1:0] count);
    logic [COUNT_W:0] sum;
    sum = {1'b0, count} + (COUNT_W+1)'(1);
    return sum[COUNT_W:1];
  endfunction

endpackage

// File: rtl/median_search.sv
// Per-axis median finder: walks the streamed histogram bins and latches the
// first bin index whose cumulative count reaches the target rank.
module median_search
  import histogram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [COUNT_W-1:0] target,
  input  logic               valid,
  input  logic [BIN_W-1:0]   binIn,
  output logic               found,
  output logic [IDX_W-1:0]   medianIdx
);

  logic [IDX_W-1:0]   idx;
  logic [COUNT_W-1:0] cum;
  logic [COUNT_W:0]   cum_sum;
  logic [COUNT_W-1:0] cum_next;

  assign cum_sum  = {1'b0, cum} + (COUNT_W+1)'(binIn);
  assign cum_next = cum_sum[COUNT_W] ? '1 : cum_sum[COUNT_W-1:0];

  // Until found, medianIdx tracks the latest index so a short stream still
  // reports the last valid bin.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx       <= '0;
      cum       <= '0;
      found     <= 1'b0;
      medianIdx <= '0;
    end else if (valid) begin
      idx <= idx + IDX_W'(1);
      cum <= cum_next;
      if (!found) begin
        medianIdx <= idx;
        if (cum_next >= target) found <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/histogram_median_sequencer.sv
// Frame controller for computeHistogram: ACCUM -> READ -> CLEAR with median search.
// Optional ACCUM watchdog and timedOut port enabled by defining FRAME_TIMEOUT_EN.
module histogram_median_sequencer
  import histogram_ctrl_pkg::*;
#(
  parameter int unsigned IMWIDTH  = IMWIDTH_DEF,
  parameter int unsigned IMHEIGHT = IMHEIGHT_DEF
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frameStart,
  input  logic             frameEnd,
  input  logic             pixelValid,
  input  logic             pixelData,
  output logic             startHistogram,
  output logic             readHistogram,
  output logic             clearHistogram,
  input  logic [BIN_W-1:0] xHistogramIn,
  input  logic [BIN_W-1:0] yHistogramIn,
  input  logic             xValid,
  input  logic             yValid,
  input  logic             histogramClear,
  output logic             busy,
  output logic [IDX_W-1:0] medianX,
  output logic [IDX_W-1:0] medianY,
  output logic             medianValid,
  output logic             frameEmpty,
  output logic             frameDropped
`ifdef FRAME_TIMEOUT_EN
  ,
  output logic             timedOut
`endif
);

  // READ spans the longer stream; with IMWIDTH >= IMHEIGHT this is IMWIDTH+1 cycles.
  localparam int unsigned READ_LAST = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
  localparam int unsigned RC_W      = $clog2(READ_LAST + 1);

  state_t             state, state_next;
  logic               post_reset;
  logic [COUNT_W-1:0] event_count;
  logic [COUNT_W-1:0] target;
  logic [RC_W-1:0]    read_cnt;
  logic               wd_expire;
  logic               search_clear;
  logic               x_take, y_take;
  logic               x_found, y_found;
  logic               found_unused;
  logic [IDX_W-1:0]   x_idx, y_idx;

  assign target       = median_target(event_count);
  assign search_clear = (state == S_GAP1);
  assign x_take       = xValid && (state == S_READ);
  assign y_take       = yValid && (state == S_READ);
  assign found_unused = x_found & y_found;

  median_search u_search_x (
    .clk       (clk),
    .reset     (reset),
    .clear     (search_clear),
    .target    (target),
    .valid     (x_take),
    .binIn     (xHistogramIn),
    .found     (x_found),
    .medianIdx (x_idx)
  );

  median_search u_search_y (
    .clk       (clk),
    .reset     (reset),
    .clear     (search_clear),
    .target    (target),
    .valid     (y_take),
    .binIn     (yHistogramIn),
    .found     (y_found),
    .medianIdx (y_idx)
  );

`ifdef FRAME_TIMEOUT_EN
  logic [31:0] wd_count;

  assign wd_expire = (state == S_ACCUM) && (wd_count == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
      timedOut <= 1'b0;
    end else begin
      wd_count <= (state == S_ACCUM) ? wd_count + 32'd1 : '0;
      if (state == S_IDLE && frameStart) timedOut <= 1'b0;
      else if (wd_expire && !frameEnd)   timedOut <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    startHistogram = 1'b0;
    readHistogram  = 1'b0;
    clearHistogram = 1'b0;
    busy           = (state != S_IDLE);
    medianValid    = (state == S_DONE);
    case (state)
      S_IDLE:  if (frameStart) state_next = S_ACCUM;
      S_ACCUM: begin
        startHistogram = pixelValid;
        if (frameEnd || wd_expire) state_next = S_GAP1;
      end
      S_GAP1:  state_next = S_READ;
      S_READ: begin
        readHistogram = 1'b1;
        if (read_cnt == RC_W'(READ_LAST)) state_next = S_GAP2;
      end
      S_GAP2:  state_next = S_CLEAR;
      S_CLEAR: begin
        clearHistogram = 1'b1;
        if (histogramClear) state_next = post_reset ? S_IDLE : S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_CLEAR;
      post_reset   <= 1'b1;
      event_count  <= '0;
      read_cnt     <= '0;
      medianX      <= '0;
      medianY      <= '0;
      frameEmpty   <= 1'b0;
      frameDropped <= 1'b0;
    end else begin
      state        <= state_next;
      frameDropped <= frameStart && (state != S_IDLE);
      read_cnt     <= (state == S_READ) ? read_cnt + RC_W'(1) : '0;
      if (state == S_IDLE && frameStart)
        event_count <= '0;
      else if (state == S_ACCUM && pixelValid && pixelData && event_count != '1)
        event_count <= event_count + COUNT_W'(1);
      // Results are latched on the CLEAR->DONE edge so they are stable during the pulse.
      if (state == S_CLEAR && histogramClear) begin
        post_reset <= 1'b0;
        if (!post_reset) begin
          frameEmpty <= (event_count == '0);
          medianX    <= (event_count == '0) ? '0 : x_idx;
          medianY    <= (event_count == '0) ? '0 : y_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_histogram_median_sequencer.sv
// Scoreboard bench: behavioural computeHistogram model plus sorted-rank median reference.
module tb_histogram_median_sequencer;

  localparam int IMW = 240;
  localparam int IMH = 180;

  logic       clk, reset;
  logic       frameStart, frameEnd, pixelValid, pixelData;
  logic       startHistogram, readHistogram, clearHistogram;
  logic [7:0] xHistogramIn, yHistogramIn;
  logic       xValid, yValid, histogramClear;
  logic       busy, medianValid, frameEmpty, frameDropped;
  logic [7:0] medianX, medianY;
`ifdef FRAME_TIMEOUT_EN
  logic       timedOut;
`endif

  typedef struct { int x; int y; int empty; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int drops_seen = 0;
  int drops_exp = 0;
  int px = 0, py = 0;
  int pre_x[$], pre_y[$];

  int hx[IMW];
  int hy[IMH];
  int rc, cc;

  histogram_median_sequencer #(
    .IMWIDTH  (IMW),
    .IMHEIGHT (IMH)
`ifdef FRAME_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frameStart     (frameStart),
    .frameEnd       (frameEnd),
    .pixelValid     (pixelValid),
    .pixelData      (pixelData),
    .startHistogram (startHistogram),
    .readHistogram  (readHistogram),
    .clearHistogram (clearHistogram),
    .xHistogramIn   (xHistogramIn),
    .yHistogramIn   (yHistogramIn),
    .xValid         (xValid),
    .yValid         (yValid),
    .histogramClear (histogramClear),
    .busy           (busy),
    .medianX        (medianX),
    .medianY        (medianY),
    .medianValid    (medianValid),
    .frameEmpty     (frameEmpty),
    .frameDropped   (frameDropped)
`ifdef FRAME_TIMEOUT_EN
    ,
    .timedOut       (timedOut)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  // Datapath model: counts events at (px,py), streams bins with one cycle latency
  // after readHistogram rises, and zeroes all bins after 3 cycles of clear.
  initial begin
    for (int i = 0; i < IMW; i++) hx[i] = 0;
    for (int i = 0; i < IMH; i++) hy[i] = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      rc <= 0; cc <= 0;
      xValid <= 0; yValid <= 0; histogramClear <= 0;
      xHistogramIn <= 0; yHistogramIn <= 0;
    end else begin
      if (startHistogram && pixelData) begin
        if (hx[px] < 255) hx[px] <= hx[px] + 1;
        if (hy[py] < 255) hy[py] <= hy[py] + 1;
      end
      if (readHistogram) begin
        rc <= rc + 1;
        xValid <= (rc < IMW);
        yValid <= (rc < IMH);
        xHistogramIn <= (rc < IMW) ? 8'(hx[rc]) : 8'd0;
        yHistogramIn <= (rc < IMH) ? 8'(hy[rc]) : 8'd0;
      end else begin
        rc <= 0; xValid <= 0; yValid <= 0;
      end
      if (clearHistogram) begin
        if (cc < 10) cc <= cc + 1;
        if (cc == 2) begin
          for (int i = 0; i < IMW; i++) hx[i] <= 0;
          for (int i = 0; i < IMH; i++) hy[i] <= 0;
          histogramClear <= 1;
        end
      end else begin
        cc <= 0;
        histogramClear <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every medianValid pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && medianValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_medianValid actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("medianX", int'(medianX), e.x);
        chk("medianY", int'(medianY), e.y);
        chk("frameEmpty", int'(frameEmpty), e.empty);
      end
    end
    if (!reset && frameDropped) drops_seen++;
  end

  // Median by rank: the ceil(n/2)-th smallest coordinate.
  function automatic int rank_median(input int q[$]);
    int s[$];
    s = q;
    if (s.size() == 0) return 0;
    s.sort();
    return s[(s.size() + 1) / 2 - 1];
  endfunction

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_read(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (readHistogram) break;
      @(posedge clk); #1;
    end
    chk("read_reached", int'(readHistogram), 1);
  endtask

  task automatic run_frame(input bit preset, input int n, input bit same_cycle, input bit drop_in_read);
    int ex[$];
    int ey[$];
    int cnt;
    exp_t e;
    @(posedge clk); #1;
    frameStart = 1;
    @(posedge clk); #1;
    frameStart = 0;
    cnt = preset ? pre_x.size() : n;
    repeat (2) begin
      pixelValid = 1; pixelData = 0;
      px = $urandom_range(0, IMW - 1); py = $urandom_range(0, IMH - 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pixelValid = $urandom_range(0, 1);
        pixelData  = !pixelValid;
        px = $urandom_range(0, IMW - 1); py = $urandom_range(0, IMH - 1);
        @(posedge clk); #1;
      end
      pixelValid = 1; pixelData = 1;
      px = preset ? pre_x[i] : $urandom_range(0, IMW - 1);
      py = preset ? pre_y[i] : $urandom_range(0, IMH - 1);
      ex.push_back(px); ey.push_back(py);
      @(posedge clk); #1;
    end
    pixelValid = 0; pixelData = 0;
    frameEnd = 1;
    if (same_cycle) begin
      frameStart = 1;
      drops_exp++;
    end
    @(posedge clk); #1;
    frameEnd = 0; frameStart = 0;
    e.x = rank_median(ex);
    e.y = rank_median(ey);
    e.empty = (cnt == 0);
    exp_q.push_back(e);
    if (drop_in_read) begin
      wait_read(50);
      frameStart = 1;
      drops_exp++;
      @(posedge clk); #1;
      frameStart = 0;
    end
    wait_idle(1000);
  endtask

  task automatic set_preset(input int xs[$], input int ys[$]);
    pre_x = xs;
    pre_y = ys;
  endtask

  initial begin
    reset = 1; frameStart = 0; frameEnd = 0; pixelValid = 0; pixelData = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clearHistogram", int'(clearHistogram), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_startHistogram", int'(startHistogram), 0);
    chk("rst_readHistogram", int'(readHistogram), 0);
    chk("rst_medianValid", int'(medianValid), 0);
    chk("rst_frameDropped", int'(frameDropped), 0);
    chk("rst_medianX", int'(medianX), 0);
    chk("rst_frameEmpty", int'(frameEmpty), 0);
    @(posedge clk); #1;
    reset = 0;
    wait_idle(50);

    // Five events, target rank 3.
    set_preset('{10, 10, 20, 30, 40}, '{5, 6, 7, 8, 9});
    run_frame(1, 0, 0, 0);

    // Empty frame.
    run_frame(0, 0, 0, 0);

    // frameStart during READ is dropped, result unaffected.
    run_frame(0, 20, 0, 1);
    chk("drops_after_read_start", drops_seen, drops_exp);

    // Reset in the middle of accumulation: scrubbed, no result.
    @(posedge clk); #1;
    frameStart = 1;
    @(posedge clk); #1;
    frameStart = 0;
    for (int i = 0; i < 50; i++) begin
      pixelValid = 1; pixelData = 1;
      px = $urandom_range(0, IMW - 1); py = $urandom_range(0, IMH - 1);
      @(posedge clk); #1;
    end
    pixelValid = 0; pixelData = 0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_clearHistogram", int'(clearHistogram), 1);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_startHistogram", int'(startHistogram), 0);
    @(posedge clk); #1;
    reset = 0;
    wait_idle(50);
    set_preset('{3}, '{7});
    run_frame(1, 0, 0, 0);

    // Last-bin boundary.
    set_preset('{IMW - 1, IMW - 1, 0}, '{IMH - 1, IMH - 1, 0});
    run_frame(1, 0, 0, 0);

    // frameEnd+frameStart together, then a back-to-back frame.
    run_frame(0, 10, 1, 0);
    run_frame(0, 12, 0, 0);
    chk("drops_same_cycle", drops_seen, drops_exp);

    for (int f = 0; f < 6; f++) run_frame(0, $urandom_range(1, 60), 0, 0);

`ifdef FRAME_TIMEOUT_EN
    begin
      int cyc;
      exp_t e;
      @(posedge clk); #1;
      frameStart = 1;
      @(posedge clk); #1;
      frameStart = 0;
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (readHistogram) break;
        cyc++;
      end
      chk("timeout_read_cycle", cyc, 101);
      chk("timedOut_set", int'(timedOut), 1);
      e.x = 0; e.y = 0; e.empty = 1;
      exp_q.push_back(e);
      wait_idle(1000);
      set_preset('{4}, '{4});
      run_frame(1, 0, 0, 0);
      chk("timedOut_cleared", int'(timedOut), 0);
    end
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("drops_total", drops_seen, drops_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
